// File: rtl/avalon_meter_pack.sv
// avalon_meter_pack: FSM state type and beat byte-count helper for the packet length meter.
package avalon_meter_pack;
    import general_pack::*;

    typedef enum logic {IDLE, IN_PKT} meter_state_t;

    // Only the eop beat can be partial; empty counts unused bytes.
    function automatic int beat_bytes(input logic eop, input int empty, input int n);
        return eop ? n - empty : n;
    endfunction

endpackage

// File: rtl/general_pack.sv
// general_pack: shared helpers for width calculations.
package general_pack;

    function automatic int log2up_func(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST stream bundle with master/slave views.
interface avalon_st_if #(parameter int DATA_WIDTH_IN_BYTES = 16);
    import general_pack::*;
    localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;
    logic                             rdy;

    modport master(output data, valid, sop, eop, empty, input rdy);
    modport slave(input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_skid_buffer.sv
// avalon_st_skid_buffer: 2-entry Avalon-ST register slice with a registered ready.
module avalon_st_skid_buffer #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) (
    input logic        clk,
    input logic        rst,
    avalon_st_if.slave  s_st,
    avalon_st_if.master m_st
);
    import general_pack::*;
    localparam int EW = log2up_func(DATA_WIDTH_IN_BYTES);
    localparam int W  = 8*DATA_WIDTH_IN_BYTES + EW + 2;

    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         r_main_vld;
    logic         r_skid_vld;
    logic         r_rdy;
    logic [W-1:0] w_in;
    logic         w_acc;
    logic         w_load;
    logic         w_skid_nxt;

    assign w_in       = {s_st.sop, s_st.eop, s_st.empty, s_st.data};
    assign w_acc      = s_st.valid && r_rdy;
    assign w_load     = !r_main_vld || m_st.rdy;
    // Ready is only ever high with the skid slot empty, so a new beat and a skid beat never collide.
    assign w_skid_nxt = !w_load && (r_skid_vld || w_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_rdy      <= !w_skid_nxt;
            r_skid_vld <= w_skid_nxt;
            if (w_load) begin
                r_main_vld <= r_skid_vld || w_acc;
                if (r_skid_vld)
                    r_main <= r_skid;
                else if (w_acc)
                    r_main <= w_in;
            end else if (w_acc) begin
                r_skid <= w_in;
            end
        end
    end

    assign s_st.rdy   = r_rdy;
    assign m_st.valid = r_main_vld;
    assign {m_st.sop, m_st.eop, m_st.empty, m_st.data} = r_main;
endmodule

// File: rtl/avalon_st_pkt_len_meter.sv
// avalon_st_pkt_len_meter: forwards an Avalon-ST stream through a skid buffer and reports per-packet byte length.
// Optional PKT_LEN_STATS_EN adds pkt_cnt / max_len statistics outputs.
module avalon_st_pkt_len_meter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           in_st,
    avalon_st_if.master          out_st,
    output logic                 len_valid,
    output logic [LEN_WIDTH-1:0] len,
    output logic                 len_err
`ifdef PKT_LEN_STATS_EN
    ,
    output logic [31:0]          pkt_cnt,
    output logic [LEN_WIDTH-1:0] max_len
`endif
);
    import avalon_meter_pack::*;
    localparam int LW1 = LEN_WIDTH + 1;

    meter_state_t         r_state;
    meter_state_t         w_state_nxt;
    logic [LEN_WIDTH-1:0] r_count;
    logic                 r_err_pend;
    logic                 r_pend;
    logic [LEN_WIDTH-1:0] r_pend_len;
    logic                 r_pend_err;
    logic                 r_len_valid;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_len_err;
    logic                 w_acc;
    logic                 w_cont;
    logic                 w_close;
    logic [LEN_WIDTH:0]   w_bytes;
    logic [LEN_WIDTH:0]   w_sum;
    logic                 w_ovf;
    logic [LEN_WIDTH-1:0] w_sat;
    logic                 w_rep;
    logic [LEN_WIDTH-1:0] w_rep_len;
    logic                 w_rep_err;
    logic                 w_rep2;
    logic                 w_pend_load;

    avalon_st_skid_buffer #(.DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES)) u_skid (
        .clk (clk),
        .rst (rst),
        .s_st(in_st),
        .m_st(out_st)
    );

    assign w_acc   = in_st.valid && in_st.rdy;
    assign w_cont  = (r_state == IN_PKT) && !in_st.sop;
    assign w_close = (r_state == IN_PKT) && in_st.sop;
    assign w_bytes = LW1'(beat_bytes(in_st.eop, 32'(in_st.empty), DATA_WIDTH_IN_BYTES));
    assign w_sum   = (w_cont ? {1'b0, r_count} : '0) + w_bytes;
    assign w_ovf   = w_sum[LEN_WIDTH];
    assign w_sat   = w_ovf ? '1 : w_sum[LEN_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = !w_acc ? r_state : (in_st.eop ? IDLE : IN_PKT);
    end

    // A sop inside a packet closes it with an error; a sop&&eop there yields a second report.
    always_comb begin
        w_rep     = w_acc && (in_st.eop || w_close);
        w_rep_len = w_close ? r_count : w_sat;
        w_rep_err = w_close || (w_cont ? r_err_pend : !in_st.sop) || w_ovf;
        w_rep2    = w_acc && w_close && in_st.eop;
    end

    // The pending slot is only full in IDLE, where at most one new report can arise per beat.
    assign w_pend_load = r_pend ? w_rep : w_rep2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_err_pend  <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_len  <= '0;
            r_pend_err  <= 1'b0;
            r_len_valid <= 1'b0;
            r_len       <= '0;
            r_len_err   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_count    <= in_st.eop ? '0 : w_sat;
                r_err_pend <= !in_st.eop && ((w_cont ? r_err_pend : !in_st.sop) || w_ovf);
            end
            r_pend <= w_pend_load;
            if (w_pend_load) begin
                r_pend_len <= r_pend ? w_rep_len : w_sat;
                r_pend_err <= r_pend && w_rep_err;
            end
            r_len_valid <= r_pend || w_rep;
            if (r_pend || w_rep) begin
                r_len     <= r_pend ? r_pend_len : w_rep_len;
                r_len_err <= r_pend ? r_pend_err : w_rep_err;
            end
        end
    end

    assign len_valid = r_len_valid;
    assign len       = r_len;
    assign len_err   = r_len_err;

`ifdef PKT_LEN_STATS_EN
    logic [31:0]          r_pkt_cnt;
    logic [LEN_WIDTH-1:0] r_max_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_max_len <= '0;
        end else if (r_len_valid) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (r_len > r_max_len)
                r_max_len <= r_len;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
    assign max_len = r_max_len;
`endif
endmodule

// File: tb/tb_avalon_st_pkt_len_meter.sv
// tb_avalon_st_pkt_len_meter: directed and randomized checks of forwarding and length reporting.
module tb_avalon_st_pkt_len_meter;
    localparam int NB   = 16;
    localparam int MAXL = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) in_if(), out_if(), in8(), out8();

    logic        len_valid, len_err, lv8, le8;
    logic [15:0] len;
    logic [7:0]  l8;
`ifdef PKT_LEN_STATS_EN
    logic [31:0] pkt_cnt, pc8;
    logic [15:0] max_len;
    logic [7:0]  ml8;
`endif

    avalon_st_pkt_len_meter #(.DATA_WIDTH_IN_BYTES(NB), .LEN_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .in_st(in_if), .out_st(out_if),
        .len_valid(len_valid), .len(len), .len_err(len_err)
`ifdef PKT_LEN_STATS_EN
        , .pkt_cnt(pkt_cnt), .max_len(max_len)
`endif
    );

    avalon_st_pkt_len_meter #(.DATA_WIDTH_IN_BYTES(NB), .LEN_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_st(in8), .out_st(out8),
        .len_valid(lv8), .len(l8), .len_err(le8)
`ifdef PKT_LEN_STATS_EN
        , .pkt_cnt(pc8), .max_len(ml8)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: packets as unbounded integer sums, saturated only when reported.
    bit           rand_rdy = 0;
    bit           open = 0;
    bit           perr = 0;
    int           sum = 0;
    int           model_cnt = 0;
    int           model_max = 0;
    logic [16:0]  rep_q[$];
    logic [133:0] beat_q[$];

    function automatic logic [15:0] sat16(input int v);
        return 16'((v > MAXL) ? MAXL : v);
    endfunction

    task automatic model_accept(input logic s, input logic e, input logic [3:0] emp);
        if (s && open) begin
            rep_q.push_back({1'b1, sat16(sum)});
            open = 0;
        end
        if (!open) begin
            open = 1;
            sum  = 0;
            perr = !s;
        end
        sum += e ? NB - int'(emp) : NB;
        if (sum > MAXL) perr = 1;
        if (e) begin
            rep_q.push_back({perr, sat16(sum)});
            open = 0;
        end
    endtask

    always @(negedge clk) out_if.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    always begin
        logic [16:0] exp;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (beat_q.size() == 2) check_eq("rdy_full", in_if.rdy, 0);
            if (len_valid) begin
                if (rep_q.size() == 0) check_eq("spurious_len", len_valid, 0);
                else begin
                    exp = rep_q.pop_front();
                    check_eq("len", len, exp[15:0]);
                    check_eq("len_err", len_err, exp[16]);
                    model_cnt++;
                    if (int'(exp[15:0]) > model_max) model_max = int'(exp[15:0]);
                end
            end
            if (out_if.valid && out_if.rdy) begin
                if (beat_q.size() == 0) check_eq("extra_beat", out_if.valid, 0);
                else check_eq("beat", {out_if.sop, out_if.eop, out_if.empty, out_if.data}, beat_q.pop_front());
            end
            if (in_if.valid && in_if.rdy) begin
                beat_q.push_back({in_if.sop, in_if.eop, in_if.empty, in_if.data});
                model_accept(in_if.sop, in_if.eop, in_if.empty);
            end
        end
    end

    // Call at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send(input logic s, input logic e, input logic [3:0] emp, input logic [127:0] d);
        int n = 0;
        in_if.valid = 1'b1;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = emp;
        in_if.data  = d;
        while (!in_if.rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq("rdy_timeout", in_if.rdy, 1);
        @(negedge clk);
        in_if.valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d [3];
        in_if.valid = 0; in_if.sop = 0; in_if.eop = 0; in_if.empty = 0; in_if.data = '0;
        in8.valid = 0; in8.sop = 0; in8.eop = 0; in8.empty = 0; in8.data = '0;
        out8.rdy = 1'b1;
        @(negedge clk);
        check_eq("rst_out", {out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data}, 0);
        check_eq("rst_len", {in_if.rdy, len_valid, len_err, len}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) d[i] = rnd128();
        send(1, 0, 0, d[0]);
        check_eq("t1_lat0", {out_if.valid, out_if.sop, out_if.data}, {2'b11, d[0]});
        send(0, 0, 0, d[1]);
        check_eq("t1_lat1", {out_if.valid, out_if.sop, out_if.data}, {2'b10, d[1]});
        send(0, 1, 5, d[2]);
        check_eq("t1_lat2", {out_if.valid, out_if.eop, out_if.empty, out_if.data}, {2'b11, 4'd5, d[2]});
        check_eq("t1_len", {len_valid, len_err, len}, {2'b10, 16'd43});
        @(negedge clk);
        check_eq("t1_once", len_valid, 0);

        send(1, 1, 15, rnd128());
        check_eq("t2_len1", {len_valid, len_err, len}, {2'b10, 16'd1});
        for (int i = 0; i < 3; i++) begin
            send(1, 1, 0, rnd128());
            check_eq("t2_b2b", {len_valid, len_err, len}, {2'b10, 16'd16});
        end

        send(1, 0, 0, rnd128());
        send(0, 0, 0, rnd128());
        send(1, 0, 0, rnd128());
        check_eq("t3_close", {len_valid, len_err, len}, {2'b11, 16'd32});
        send(0, 1, 0, rnd128());
        check_eq("t3_next", {len_valid, len_err, len}, {2'b10, 16'd32});
        send(1, 0, 0, rnd128());
        send(1, 1, 4, rnd128());
        check_eq("t3_close1", {len_valid, len_err, len}, {2'b11, 16'd16});
        @(negedge clk);
        check_eq("t3_single", {len_valid, len_err, len}, {2'b10, 16'd12});

        for (int i = 0; i < 20; i++) begin
            int n = 0;
            in8.valid = 1'b1;
            in8.sop   = (i == 0);
            in8.eop   = (i == 19);
            in8.data  = 128'(i);
            while (!in8.rdy && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check_eq("rdy8_timeout", in8.rdy, 1);
            @(negedge clk);
        end
        in8.valid = 1'b0;
        check_eq("t4_sat", {lv8, le8, l8}, {2'b11, 8'd255});

        send(1, 0, 0, rnd128());
        send(0, 0, 0, rnd128());
        rst = 1'b1;
        #1;
        check_eq("t5_rst_out", {out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data}, 0);
        check_eq("t5_rst_len", {in_if.rdy, len_valid, len_err, len}, 0);
`ifdef PKT_LEN_STATS_EN
        check_eq("t5_rst_stats", {pkt_cnt, max_len}, 0);
`endif
        beat_q.delete();
        rep_q.delete();
        open = 0;
        model_cnt = 0;
        model_max = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t5_rdy_in_rst", in_if.rdy, 0);
        rst = 1'b0;
        send(1, 0, 0, rnd128());
        send(0, 1, 3, rnd128());
        check_eq("t5_after", {len_valid, len_err, len}, {2'b10, 16'd29});

        rand_rdy = 1;
        for (int p = 0; p < 200; p++) begin
            int nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                logic s = (b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
                logic e = (b == nb - 1);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                send(s, e, 4'($urandom_range(0, 15)), rnd128());
            end
        end
        rand_rdy = 0;
        repeat (10) @(negedge clk);
        check_eq("beats_left", beat_q.size(), 0);
        check_eq("reps_left", rep_q.size(), 0);
`ifdef PKT_LEN_STATS_EN
        check_eq("pkt_cnt", pkt_cnt, model_cnt);
        check_eq("max_len", max_len, model_max);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
